mux_4_rr_arbiter: RTL and testbench

Four-requester round-robin arbiter that shares the 4-bit `mux_4_1` datapath between four valid/ready producers and presents the selected beat on one registered valid/ready output. It computes the 2-bit select for `mux_4_1`, grants one requester per accepted beat, and rotates priority so every continuously valid requester is served within 4 output transfers. It sits between independent 4-bit sources and a single downstream consumer.

---
 rtl/mux_arb_pkg.sv | 19 +
 rtl/mux_4_1.sv | 22 ++
 rtl/mux_4_rr_arbiter.sv | 84 ++++++++
 tb/tb_mux_4_rr_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter around mux_4_1.
package mux_arb_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 4;

  typedef logic [1:0] req_idx_t;

  // First index at or after ptr (mod 4) with valid set; returns ptr when none are valid.
  function automatic req_idx_t rr_pick(logic [3:0] valid, req_idx_t ptr);
    req_idx_t idx;
    rr_pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + req_idx_t'(k);
      if (valid[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux_4_1.sv
// Plain 4-to-1 multiplexer for 4-bit payloads.
module mux_4_1 (
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [1:0] sel,
  output logic [3:0] out
);

  always_comb begin
    out = in0;
    unique case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/mux_4_rr_arbiter.sv
// Round-robin arbiter sharing mux_4_1 among four valid/ready producers,
// with a single registered valid/ready output stage.
module mux_4_rr_arbiter
  import mux_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [N_REQ-1:0]  in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_id,
  input  logic              out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  req_idx_t          out_id_q, out_id_d;
  req_idx_t          ptr_q, ptr_d;

  logic              can_load;
  logic              any_valid;
  logic              load;
  req_idx_t          grant;
  logic [DATA_W-1:0] mux_out;

  assign can_load  = !out_valid_q || out_ready;
  assign any_valid = |in_valid;
  assign grant     = rr_pick(in_valid, ptr_q);
  // Gating with rst keeps in_ready low while reset is held.
  assign load      = !rst && can_load && any_valid;

  mux_4_1 u_mux (
    .in0 (in_data0),
    .in1 (in_data1),
    .in2 (in_data2),
    .in3 (in_data3),
    .sel (grant),
    .out (mux_out)
  );

  always_comb begin
    in_ready = '0;
    if (load) in_ready[grant] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_out;
      out_id_d    = grant;
      ptr_d       = grant + req_idx_t'(1);
    end else if (can_load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_mux_4_rr_arbiter.sv
// Scoreboard bench for mux_4_rr_arbiter: directed vectors push expected beats,
// a negedge monitor pops and compares each beat the output stage delivers.
module tb_mux_4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_id;
  logic       out_ready;

  int checks = 0;
  int errors = 0;
  logic [5:0] sb[$];

  mux_4_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive inputs, check in_ready, log expected beat, advance one cycle.
  task automatic cyc(input logic [3:0] v, input logic ordy, input logic [3:0] er,
                     input bit push, input logic [1:0] eid, input logic [3:0] ed);
    in_valid  = v;
    out_ready = ordy;
    #2;
    chk("in_ready", {4'h0, in_ready}, {4'h0, er});
    if (push) sb.push_back({eid, ed});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [5:0] e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got id=%0d data=%h expected none", out_id, out_data);
      end else begin
        e = sb.pop_front();
        if ({out_id, out_data} !== e) begin
          errors++;
          $display("FAIL beat got id=%0d data=%h expected id=%0d data=%h t=%0t",
                   out_id, out_data, e[5:4], e[3:0], $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    in_data0 = 4'h1; in_data1 = 4'h2; in_data2 = 4'hA; in_data3 = 4'h4;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {4'h0, in_ready}, 8'h00);
    chk("reset_out_valid", {7'h0, out_valid}, 8'h00);
    chk("reset_out_data", {4'h0, out_data}, 8'h00);
    chk("reset_out_id", {6'h0, out_id}, 8'h00);
    rst = 1'b0;

    // Single requester 2 right after reset
    cyc(4'b0100, 1'b1, 4'b0100, 1, 2'd2, 4'hA);
    chk("single_out_valid", {7'h0, out_valid}, 8'h01);
    chk("single_out_id", {6'h0, out_id}, 8'h02);
    chk("single_out_data", {4'h0, out_data}, 8'h0A);

    // ptr is 3: requesters 0/1 only -> 0, 1, 0
    in_data2 = 4'h3;
    cyc(4'b0011, 1'b1, 4'b0001, 1, 2'd0, 4'h1);
    cyc(4'b0011, 1'b1, 4'b0010, 1, 2'd1, 4'h2);
    cyc(4'b0011, 1'b1, 4'b0001, 1, 2'd0, 4'h1);

    // Idle drain; ptr stays at 1
    cyc(4'b0000, 1'b1, 4'b0000, 0, 2'd0, 4'h0);
    chk("drain_out_valid", {7'h0, out_valid}, 8'h00);
    chk("drain_out_id", {6'h0, out_id}, 8'h00);
    chk("drain_out_data", {4'h0, out_data}, 8'h01);
    cyc(4'b1111, 1'b1, 4'b0010, 1, 2'd1, 4'h2);
    cyc(4'b1000, 1'b1, 4'b1000, 1, 2'd3, 4'h4);

    // All valid, full throughput, from ptr 0
    for (int i = 0; i < 8; i++) begin
      logic [1:0] id;
      id = 2'(i % 4);
      cyc(4'b1111, 1'b1, 4'b0001 << id, 1, id, 4'(id) + 4'h1);
    end

    // Backpressure with id 1 / data 5 held
    cyc(4'b1111, 1'b1, 4'b0001, 1, 2'd0, 4'h1);
    in_data1 = 4'h5;
    cyc(4'b1111, 1'b1, 4'b0010, 1, 2'd1, 4'h5);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1111, 1'b0, 4'b0000, 0, 2'd0, 4'h0);
      chk("stall_out_valid", {7'h0, out_valid}, 8'h01);
      chk("stall_out_id", {6'h0, out_id}, 8'h01);
      chk("stall_out_data", {4'h0, out_data}, 8'h05);
    end
    cyc(4'b1111, 1'b1, 4'b0100, 1, 2'd2, 4'h3);

    // Reset mid-stream discards the held beat
    cyc(4'b1111, 1'b1, 4'b1000, 1, 2'd3, 4'h4);
    rst = 1'b1;
    in_valid = 4'b1111;
    #2;
    chk("midrst_in_ready", {4'h0, in_ready}, 8'h00);
    @(posedge clk);
    #1;
    sb.delete();
    chk("midrst_out_valid", {7'h0, out_valid}, 8'h00);
    chk("midrst_out_id", {6'h0, out_id}, 8'h00);
    chk("midrst_out_data", {4'h0, out_data}, 8'h00);
    rst = 1'b0;
    cyc(4'b1111, 1'b1, 4'b0001, 1, 2'd0, 4'h1);
    cyc(4'b0000, 1'b1, 4'b0000, 0, 2'd0, 4'h0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d expected pending=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
